// File: rtl/plic_regfile_if.sv
// Register-window bus for the interrupt controller register file.
// Single-cycle request, one response strobe per accepted request.
interface plic_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 24
) ();
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [31:0]           bus_wdata;
  logic [31:0]           bus_rdata;
  logic                  bus_rvalid;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_rvalid
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_rvalid
  );
endinterface

// File: rtl/plic_regfile.sv
// Priority/pending/enable/threshold registers for the external interrupt
// controller, plus the claim/complete protocol with a nesting stack.
module plic_regfile #(
  parameter int unsigned EXT_IRQ_NUM = 31,
  parameter int unsigned PRIO_WIDTH  = 3,
  parameter int unsigned NEST_DEPTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 24
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  plic_regfile_if.slave                         bus,
  input  logic [EXT_IRQ_NUM:0]                  plic_reg_gate,
  input  logic [7:0]                            final_id,
  input  logic                                  ext_irq,
  output logic [EXT_IRQ_NUM:0]                  ip_r,
  output logic [EXT_IRQ_NUM:0]                  ie_r,
  output logic [PRIO_WIDTH*(EXT_IRQ_NUM+1)-1:0] prio_r_1d,
  output logic [PRIO_WIDTH-1:0]                 threshold_r,
  output logic [7:0]                            claim_id,
  output logic [7:0]                            cmplt_id
);

  localparam int unsigned NSRC = EXT_IRQ_NUM + 1;
  localparam int unsigned AW2  = ADDR_WIDTH - 2;
  localparam int unsigned IW   = $clog2(NEST_DEPTH);
  localparam int unsigned CW   = IW + 1;
  localparam logic [EXT_IRQ_NUM:0] ID_MASK = ~(NSRC'(1));

  logic [PRIO_WIDTH-1:0] prio_q [NSRC];
  logic [7:0]            stk    [NEST_DEPTH];
  logic [CW-1:0]         cnt;

  logic [AW2-1:0]        waddr;
  logic [9:0]            widx;
  logic                  prio_sel, pend_sel, en_sel, thr_sel, clm_sel;
  logic                  prio_we, ie_we, thr_we;
  logic                  claim_ok, cmplt_ok;
  logic [EXT_IRQ_NUM:0]  clr_mask, ie_next;
  logic [31:0]           rd_data;

  // Word-granular decode: bits[1:0] of the byte address are don't-care.
  assign waddr    = bus.bus_addr[ADDR_WIDTH-1:2];
  assign widx     = waddr[9:0];
  assign prio_sel = (waddr[AW2-1:10] == '0);
  assign pend_sel = (waddr[AW2-1:10] == (AW2-10)'(1));
  assign en_sel   = (waddr[AW2-1:10] == (AW2-10)'(2));
  assign thr_sel  = (waddr == AW2'(32'h0008_0000));
  assign clm_sel  = (waddr == AW2'(32'h0008_0001));

  assign prio_we  = bus.bus_req & bus.bus_we & prio_sel;
  assign ie_we    = bus.bus_req & bus.bus_we & en_sel;
  assign thr_we   = bus.bus_req & bus.bus_we & thr_sel;

  assign claim_ok = bus.bus_req & ~bus.bus_we & clm_sel & ext_irq &
                    (final_id != 8'd0) & (32'(cnt) < NEST_DEPTH);
  // claim_id mirrors the stack top and is never 0 while cnt>0.
  assign cmplt_ok = bus.bus_req & bus.bus_we & clm_sel & (cnt != '0) &
                    (bus.bus_wdata[7:0] == claim_id);

  always_comb begin
    clr_mask = '0;
    ie_next  = ie_r;
    for (int unsigned i = 1; i < NSRC; i++) begin
      if (claim_ok && (32'(final_id) == i)) clr_mask[i] = 1'b1;
      if (ie_we && (32'(widx) == i / 32)) ie_next[i] = bus.bus_wdata[i[4:0]];
    end
  end

  always_comb begin
    rd_data = '0;
    if (prio_sel) begin
      for (int unsigned i = 1; i < NSRC; i++)
        if (32'(widx) == i) rd_data[PRIO_WIDTH-1:0] = prio_q[i];
    end
    if (pend_sel) begin
      for (int unsigned i = 0; i < NSRC; i++)
        if (32'(widx) == i / 32) rd_data[i[4:0]] = ip_r[i];
    end
    if (en_sel) begin
      for (int unsigned i = 0; i < NSRC; i++)
        if (32'(widx) == i / 32) rd_data[i[4:0]] = ie_r[i];
    end
    if (thr_sel) rd_data[PRIO_WIDTH-1:0] = threshold_r;
    if (clm_sel && claim_ok) rd_data[7:0] = final_id;
  end

  always_comb begin
    prio_r_1d = '0;
    for (int unsigned i = 0; i < NSRC; i++)
      prio_r_1d[i*PRIO_WIDTH +: PRIO_WIDTH] = prio_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NSRC; i++) prio_q[i] <= '0;
      for (int unsigned d = 0; d < NEST_DEPTH; d++) stk[d] <= '0;
      ip_r           <= '0;
      ie_r           <= '0;
      threshold_r    <= '0;
      cnt            <= '0;
      claim_id       <= '0;
      cmplt_id       <= '0;
      bus.bus_rvalid <= 1'b0;
      bus.bus_rdata  <= '0;
    end else begin
      // Claim clear is applied after the gate set so it wins a same-cycle race.
      ip_r <= (ip_r | plic_reg_gate) & ~clr_mask & ID_MASK;
      ie_r <= ie_next;
      if (prio_we) begin
        for (int unsigned i = 1; i < NSRC; i++)
          if (32'(widx) == i) prio_q[i] <= bus.bus_wdata[PRIO_WIDTH-1:0];
      end
      if (thr_we) threshold_r <= bus.bus_wdata[PRIO_WIDTH-1:0];

      bus.bus_rvalid <= bus.bus_req;
      if (bus.bus_req) bus.bus_rdata <= rd_data;

      cmplt_id <= '0;
      if (claim_ok) begin
        stk[cnt[IW-1:0]] <= final_id;
        cnt              <= cnt + CW'(1);
        claim_id         <= final_id;
      end else if (cmplt_ok) begin
        cnt      <= cnt - CW'(1);
        claim_id <= (cnt > CW'(1)) ? stk[IW'(cnt - CW'(2))] : 8'd0;
        cmplt_id <= bus.bus_wdata[7:0];
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.bus_addr[1:0], bus.bus_wdata, plic_reg_gate[0]};

endmodule

// File: tb/tb_plic_regfile.sv
// Scoreboard bench for plic_regfile: expected read data is queued at issue
// time and compared when the response strobe arrives.
module tb_plic_regfile;
  localparam int unsigned EXT_IRQ_NUM = 31;
  localparam int unsigned PRIO_WIDTH  = 3;
  localparam int unsigned NEST_DEPTH  = 4;
  localparam int unsigned ADDR_WIDTH  = 24;

  localparam logic [23:0] A_PRIO = 24'h000000;
  localparam logic [23:0] A_PEND = 24'h001000;
  localparam logic [23:0] A_EN   = 24'h002000;
  localparam logic [23:0] A_THR  = 24'h200000;
  localparam logic [23:0] A_CLM  = 24'h200004;

  logic clk = 1'b0;
  logic rstn;
  logic [EXT_IRQ_NUM:0] plic_reg_gate;
  logic [7:0] final_id;
  logic ext_irq;
  logic [EXT_IRQ_NUM:0] ip_r, ie_r;
  logic [PRIO_WIDTH*(EXT_IRQ_NUM+1)-1:0] prio_r_1d;
  logic [PRIO_WIDTH-1:0] threshold_r;
  logic [7:0] claim_id, cmplt_id;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_val [$];
  logic        sb_chk [$];
  string       sb_name [$];

  plic_regfile_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  plic_regfile #(
    .EXT_IRQ_NUM(EXT_IRQ_NUM),
    .PRIO_WIDTH (PRIO_WIDTH),
    .NEST_DEPTH (NEST_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .bus          (bus),
    .plic_reg_gate(plic_reg_gate),
    .final_id     (final_id),
    .ext_irq      (ext_irq),
    .ip_r         (ip_r),
    .ie_r         (ie_r),
    .prio_r_1d    (prio_r_1d),
    .threshold_r  (threshold_r),
    .claim_id     (claim_id),
    .cmplt_id     (cmplt_id)
  );

  always #5 clk = ~clk;

  // Issue at a negedge; accepted at the following posedge.
  task automatic rd(input logic [23:0] a, input logic [31:0] e, input string n);
    bus.bus_req = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = a; bus.bus_wdata = '0;
    sb_val.push_back(e); sb_chk.push_back(1'b1); sb_name.push_back(n);
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input string n);
    bus.bus_req = 1'b1; bus.bus_we = 1'b1; bus.bus_addr = a; bus.bus_wdata = d;
    sb_val.push_back('0); sb_chk.push_back(1'b0); sb_name.push_back(n);
  endtask

  task automatic idle();
    bus.bus_req = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
  endtask

  task automatic sb_pop();
    logic [31:0] e;
    logic        c;
    string       n;
    @(negedge clk);
    if (sb_val.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: response with nothing expected");
    end else begin
      e = sb_val.pop_front(); c = sb_chk.pop_front(); n = sb_name.pop_front();
      checks++;
      if (bus.bus_rvalid !== 1'b1) begin
        errors++;
        $display("FAIL %s_rvalid: got %b want 1", n, bus.bus_rvalid);
      end
      if (c) begin
        checks++;
        if (bus.bus_rdata !== e) begin
          errors++;
          $display("FAIL %s_rdata: got %h want %h", n, bus.bus_rdata, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.bus_rvalid, bus.bus_rdata, claim_id, cmplt_id, ip_r, ie_r, threshold_r} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rvalid=%b rdata=%h claim=%h cmplt=%h ip=%h ie=%h thr=%h",
               bus.bus_rvalid, bus.bus_rdata, claim_id, cmplt_id, ip_r, ie_r, threshold_r);
    end
    checks++;
    if (prio_r_1d !== '0) begin
      errors++;
      $display("FAIL reset_prio: got %h want 0", prio_r_1d);
    end
    rstn = 1'b1;
    rd(A_PRIO + 24'h0C, 32'h0, "rst_prio3");
    sb_pop(); rd(A_PEND, 32'h0, "rst_pend0");
    sb_pop(); rd(A_THR, 32'h0, "rst_thr");
    sb_pop(); rd(A_CLM, 32'h0, "rst_claim");
    sb_pop(); idle();
    @(negedge clk);
    checks++;
    if (bus.bus_rvalid !== 1'b0 || claim_id !== 8'd0 || cmplt_id !== 8'd0) begin
      errors++;
      $display("FAIL rst_idle: rvalid=%b claim=%h cmplt=%h want 0 0 0",
               bus.bus_rvalid, claim_id, cmplt_id);
    end
  endtask

  task automatic test_registers();
    wr(A_PRIO + 24'h14, 32'hFF, "prio5_wr");
    sb_pop(); rd(A_PRIO + 24'h14, 32'h7, "prio5_rd");
    sb_pop(); idle();
    @(negedge clk);
    checks++;
    if (bus.bus_rvalid !== 1'b0 || bus.bus_rdata !== 32'h7) begin
      errors++;
      $display("FAIL rdata_hold: rvalid=%b rdata=%h want 0 00000007", bus.bus_rvalid, bus.bus_rdata);
    end
    checks++;
    if (prio_r_1d[17:15] !== 3'b111 || prio_r_1d[14:0] !== '0) begin
      errors++;
      $display("FAIL prio5_field: got %h want 38000", prio_r_1d);
    end
    wr(A_PRIO, 32'h7, "prio0_wr");
    sb_pop(); rd(A_PRIO, 32'h0, "prio0_rd");
    sb_pop(); wr(A_PRIO + 24'h7C, 32'h6, "prio31_wr");
    sb_pop(); rd(A_PRIO + 24'h7D, 32'h6, "prio31_rd_lowbits");
    sb_pop(); wr(A_PRIO + 24'h80, 32'h5, "prio32_wr");
    sb_pop(); rd(A_PRIO + 24'h80, 32'h0, "prio32_rd");
    sb_pop(); wr(A_THR, 32'h1D, "thr_wr");
    sb_pop(); rd(A_THR, 32'h5, "thr_rd");
    sb_pop(); wr(A_EN, 32'hFFFF_FFFF, "ie_all_wr");
    sb_pop(); rd(A_EN, 32'hFFFF_FFFE, "ie_all_rd");
    sb_pop(); wr(A_EN + 24'h4, 32'hFFFF_FFFF, "ie_w1_wr");
    sb_pop(); rd(A_EN + 24'h4, 32'h0, "ie_w1_rd");
    sb_pop(); rd(A_PEND + 24'h4, 32'h0, "pend_w1_rd");
    sb_pop(); wr(24'h300000, 32'h1234, "unmapped_wr");
    sb_pop(); rd(24'h300000, 32'h0, "unmapped_rd");
    sb_pop(); wr(A_PEND, 32'hFFFF_FFFF, "pend_ro_wr");
    sb_pop(); rd(A_PEND, 32'h0, "pend_ro_rd");
    sb_pop(); idle();
    checks++;
    if (threshold_r !== 3'd5 || prio_r_1d[95:93] !== 3'd6) begin
      errors++;
      $display("FAIL reg_outputs: thr=%h prio31=%h want 5 6", threshold_r, prio_r_1d[95:93]);
    end
  endtask

  task automatic test_claim();
    plic_reg_gate = 32'h20;
    @(negedge clk);
    plic_reg_gate = '0;
    checks++;
    if (ip_r !== 32'h20) begin
      errors++;
      $display("FAIL gate_set: ip=%h want 00000020", ip_r);
    end
    wr(A_EN, 32'h20, "ie_wr");
    sb_pop(); rd(A_EN, 32'h20, "ie_rd");
    sb_pop(); rd(A_PEND, 32'h20, "pend_rd");
    final_id = 8'd5; ext_irq = 1'b1;
    sb_pop(); rd(A_CLM, 32'd5, "claim5");
    sb_pop(); idle(); ext_irq = 1'b0;
    checks++;
    if (ip_r[5] !== 1'b0 || claim_id !== 8'd5 || ie_r !== 32'h20) begin
      errors++;
      $display("FAIL claim5_state: ip5=%b claim=%h ie=%h want 0 05 00000020", ip_r[5], claim_id, ie_r);
    end
    rd(A_CLM, 32'd0, "claim_noirq");
    sb_pop(); idle();
    checks++;
    if (claim_id !== 8'd5) begin
      errors++;
      $display("FAIL claim_noirq_state: claim=%h want 05", claim_id);
    end
  endtask

  task automatic test_nesting();
    final_id = 8'd9; ext_irq = 1'b1;
    rd(A_CLM, 32'd9, "claim9");
    sb_pop(); idle(); ext_irq = 1'b0;
    checks++;
    if (claim_id !== 8'd9) begin
      errors++;
      $display("FAIL nest_top9: claim=%h want 09", claim_id);
    end
    wr(A_CLM, 32'd5, "cmplt5_ooo");
    sb_pop(); idle();
    checks++;
    if (cmplt_id !== 8'd0 || claim_id !== 8'd9) begin
      errors++;
      $display("FAIL cmplt_ooo: cmplt=%h claim=%h want 00 09", cmplt_id, claim_id);
    end
    wr(A_CLM, 32'd9, "cmplt9");
    sb_pop(); idle();
    checks++;
    if (cmplt_id !== 8'd9 || claim_id !== 8'd5) begin
      errors++;
      $display("FAIL cmplt9: cmplt=%h claim=%h want 09 05", cmplt_id, claim_id);
    end
    @(negedge clk);
    checks++;
    if (cmplt_id !== 8'd0) begin
      errors++;
      $display("FAIL cmplt9_pulse: cmplt=%h want 00", cmplt_id);
    end
    wr(A_CLM, 32'd5, "cmplt5");
    sb_pop(); idle();
    checks++;
    if (cmplt_id !== 8'd5 || claim_id !== 8'd0) begin
      errors++;
      $display("FAIL cmplt5: cmplt=%h claim=%h want 05 00", cmplt_id, claim_id);
    end
    wr(A_CLM, 32'd0, "cmplt_empty");
    sb_pop(); idle();
    checks++;
    if (cmplt_id !== 8'd0 || claim_id !== 8'd0) begin
      errors++;
      $display("FAIL cmplt_empty: cmplt=%h claim=%h want 00 00", cmplt_id, claim_id);
    end
  endtask

  task automatic test_stack_full();
    ext_irq = 1'b1;
    for (int k = 1; k <= int'(NEST_DEPTH); k++) begin
      final_id = 8'(k);
      rd(A_CLM, 32'(k), "claim_fill");
      sb_pop();
    end
    idle();
    plic_reg_gate = 32'h80;
    @(negedge clk);
    plic_reg_gate = '0;
    final_id = 8'd7;
    rd(A_CLM, 32'd0, "claim_full");
    sb_pop(); idle(); ext_irq = 1'b0;
    checks++;
    if (ip_r[7] !== 1'b1 || claim_id !== 8'd4) begin
      errors++;
      $display("FAIL full_state: ip7=%b claim=%h want 1 04", ip_r[7], claim_id);
    end
    for (int k = int'(NEST_DEPTH); k >= 1; k--) begin
      wr(A_CLM, 32'(k), "cmplt_drain");
      sb_pop(); idle();
      checks++;
      if (cmplt_id !== 8'(k) || claim_id !== 8'(k - 1)) begin
        errors++;
        $display("FAIL drain_%0d: cmplt=%h claim=%h want %h %h", k, cmplt_id, claim_id, 8'(k), 8'(k - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Claim/gate race on id 3, then a mid-access reset.
    final_id = 8'd3; ext_irq = 1'b1;
    plic_reg_gate = 32'h8;
    rd(A_CLM, 32'd3, "claim3_race");
    sb_pop(); plic_reg_gate = '0; ext_irq = 1'b0;
    rd(A_PEND, 32'h80, "pend_after_race");
    sb_pop(); idle();
    checks++;
    if (ip_r[3] !== 1'b0 || claim_id !== 8'd3) begin
      errors++;
      $display("FAIL race_state: ip3=%b claim=%h want 0 03", ip_r[3], claim_id);
    end
    rd(A_EN, 32'h20, "pre_reset_rd");
    rstn = 1'b0;
    void'(sb_val.pop_back()); void'(sb_chk.pop_back()); void'(sb_name.pop_back());
    @(negedge clk);
    idle(); rstn = 1'b1;
    checks++;
    if ({bus.bus_rvalid, bus.bus_rdata, claim_id, cmplt_id, ip_r, ie_r, threshold_r} !== '0 ||
        prio_r_1d !== '0) begin
      errors++;
      $display("FAIL reset_mid: rvalid=%b rdata=%h claim=%h ip=%h ie=%h thr=%h prio=%h",
               bus.bus_rvalid, bus.bus_rdata, claim_id, ip_r, ie_r, threshold_r, prio_r_1d);
    end
    @(negedge clk);
    checks++;
    if (bus.bus_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_late: rvalid=%b want 0", bus.bus_rvalid);
    end
  endtask

  initial begin
    rstn = 1'b0; plic_reg_gate = '0; final_id = '0; ext_irq = 1'b0;
    idle();
    @(negedge clk);
    test_reset();
    test_registers();
    test_claim();
    test_nesting();
    test_stack_full();
    test_back_to_back();
    if (sb_val.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries", sb_val.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
